// File: rtl/dma_writer_frame.sv
// dma_writer_frame: stream-to-AXI4 frame DMA writer with 4 KiB-safe incrementing bursts.
// Optional byte-enable pass-through is enabled by defining DMA_WR_KEEP_EN.
module dma_writer_frame #(
    parameter int DataBits       = 64,
    parameter int AddrBits       = 32,
    parameter int BurstSize      = 16,
    parameter int FifoDepth      = 64,
    parameter int MaxOutstanding = 4,
    parameter int CountBits      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic [DataBits-1:0]   din_data,
    input  logic                  din_eof,
`ifdef DMA_WR_KEEP_EN
    input  logic [DataBits/8-1:0] din_keep,
`endif
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [AddrBits-1:0]   cfg_addr,
    output logic                  mst_awvalid,
    input  logic                  mst_awready,
    output logic [AddrBits-1:0]   mst_awaddr,
    output logic [7:0]            mst_awlen,
    output logic [2:0]            mst_awsize,
    output logic [1:0]            mst_awburst,
    output logic [3:0]            mst_awid,
    output logic                  mst_wvalid,
    input  logic                  mst_wready,
    output logic [DataBits-1:0]   mst_wdata,
    output logic [DataBits/8-1:0] mst_wstrb,
    output logic                  mst_wlast,
    input  logic                  mst_bvalid,
    output logic                  mst_bready,
    input  logic [1:0]            mst_bresp,
    output logic                  done,
    output logic [CountBits-1:0]  done_words,
    output logic [1:0]            done_error
);

    localparam int BytesPerWord = DataBits / 8;
    localparam int SizeLog      = $clog2(BytesPerWord);
    localparam int PtrBits      = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int UsedBits     = $clog2(FifoDepth + 1);
    localparam int LenBits      = 13;
`ifdef DMA_WR_KEEP_EN
    localparam int EntryBits    = DataBits + BytesPerWord;
`else
    localparam int EntryBits    = DataBits;
`endif

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PREP0 = 3'd1;
    localparam logic [2:0] S_PREP1 = 3'd2;
    localparam logic [2:0] S_WAITF = 3'd3;
    localparam logic [2:0] S_ISSUE = 3'd4;
    localparam logic [2:0] S_BURST = 3'd5;
    localparam logic [2:0] S_WRESP = 3'd6;

    logic [2:0]           r_state;
    logic [AddrBits-1:0]  r_addr;
    logic [LenBits-1:0]   r_until;
    logic [LenBits-1:0]   r_len;
    logic [LenBits-1:0]   r_beat;
    logic                 r_final;
    logic [CountBits-1:0] r_count;
    logic [1:0]           r_err;
    logic [3:0]           r_outst;
    logic                 r_eof_held;
    logic                 r_awvalid;
    logic [AddrBits-1:0]  r_awaddr;
    logic [7:0]           r_awlen;
    logic                 r_wvalid;
    logic [DataBits-1:0]  r_wdata;
    logic                 r_wlast;
    logic                 r_done;
    logic [CountBits-1:0] r_done_words;
    logic [1:0]           r_done_error;

    logic [EntryBits-1:0] r_mem [FifoDepth];
    logic [PtrBits-1:0]   r_wr_ptr;
    logic [PtrBits-1:0]   r_rd_ptr;
    logic [UsedBits-1:0]  r_used;

    logic                 w_din_hs;
    logic                 w_cfg_hs;
    logic                 w_aw_hs;
    logic                 w_b_hs;
    logic                 w_fifo_full;
    logic                 w_buf_free;
    logic                 w_beat_go;
    logic                 w_last_beat;
    logic                 w_final_decide;
    logic                 w_go_issue;
    logic                 w_issue_ok;
    logic                 w_resp_clear;
    logic [PtrBits-1:0]   w_wr_ptr_nxt;
    logic [PtrBits-1:0]   w_rd_ptr_nxt;
    logic [EntryBits-1:0] w_wr_entry;
    logic [EntryBits-1:0] w_rd_entry;

    assign w_fifo_full    = (r_used == UsedBits'(FifoDepth));
    assign din_ready      = !w_fifo_full && !r_eof_held;
    assign cfg_ready      = (r_state == S_IDLE);
    assign w_din_hs       = din_valid && din_ready;
    assign w_cfg_hs       = cfg_valid && cfg_ready;
    assign w_aw_hs        = r_awvalid && mst_awready;
    assign w_b_hs         = mst_bvalid;
    assign w_buf_free     = !r_wvalid || mst_wready;
    assign w_beat_go      = (r_state == S_BURST) && w_buf_free && (r_used != UsedBits'(0));
    assign w_last_beat    = (r_beat == r_len - LenBits'(1));
    // The fifo never holds a second frame's EOF, so a held EOF means the fifo ends the frame.
    assign w_final_decide = (r_state == S_WAITF) && r_eof_held && (32'(r_used) <= 32'(r_len));
    assign w_go_issue     = (r_state == S_WAITF) && (w_final_decide || (32'(r_used) >= 32'(r_len)));
    assign w_issue_ok     = (r_state == S_ISSUE) && !r_awvalid && (r_outst != 4'(MaxOutstanding));
    assign w_resp_clear   = !r_wvalid && !r_awvalid && (r_outst == 4'd0);

    assign w_wr_ptr_nxt   = (r_wr_ptr == PtrBits'(FifoDepth - 1)) ? PtrBits'(0) : r_wr_ptr + PtrBits'(1);
    assign w_rd_ptr_nxt   = (r_rd_ptr == PtrBits'(FifoDepth - 1)) ? PtrBits'(0) : r_rd_ptr + PtrBits'(1);
    assign w_rd_entry     = r_mem[r_rd_ptr];
`ifdef DMA_WR_KEEP_EN
    assign w_wr_entry     = {din_keep, din_data};
`else
    assign w_wr_entry     = din_data;
`endif

    // Fifo storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_din_hs) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    // Fifo pointers, fill level and the held-EOF flag that backpressures the stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_used     <= '0;
            r_eof_held <= 1'b0;
        end else begin
            if (w_din_hs) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_beat_go) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_din_hs, w_beat_go})
                2'b10:   r_used <= r_used + UsedBits'(1);
                2'b01:   r_used <= r_used - UsedBits'(1);
                default: r_used <= r_used;
            endcase
            if (w_din_hs && din_eof) begin
                r_eof_held <= 1'b1;
            end else if (w_final_decide) begin
                r_eof_held <= 1'b0;
            end
        end
    end

    // Frame control: address, burst sizing, AW issue, word count and completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_until      <= '0;
            r_len        <= '0;
            r_beat       <= '0;
            r_final      <= 1'b0;
            r_count      <= '0;
            r_err        <= 2'b00;
            r_awvalid    <= 1'b0;
            r_awaddr     <= '0;
            r_awlen      <= 8'd0;
            r_done       <= 1'b0;
            r_done_words <= '0;
            r_done_error <= 2'b00;
        end else begin
            r_done <= 1'b0;
            if (w_aw_hs) begin
                r_awvalid <= 1'b0;
            end
            if (w_b_hs && (mst_bresp > r_err)) begin
                r_err <= mst_bresp;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_cfg_hs) begin
                        r_addr  <= cfg_addr;
                        r_count <= '0;
                        r_err   <= 2'b00;
                        r_final <= 1'b0;
                        r_beat  <= '0;
                        r_state <= S_PREP0;
                    end
                end
                S_PREP0: begin
                    r_until <= (LenBits'(4096) - {1'b0, r_addr[11:0]}) >> SizeLog;
                    r_state <= S_PREP1;
                end
                S_PREP1: begin
                    r_len   <= (LenBits'(BurstSize) < r_until) ? LenBits'(BurstSize) : r_until;
                    r_state <= S_WAITF;
                end
                S_WAITF: begin
                    if (w_final_decide) begin
                        r_len   <= LenBits'(r_used);
                        r_final <= 1'b1;
                        r_state <= S_ISSUE;
                    end else if (w_go_issue) begin
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_issue_ok) begin
                        r_awvalid <= 1'b1;
                        r_awaddr  <= r_addr;
                        r_awlen   <= 8'(r_len - LenBits'(1));
                        r_addr    <= r_addr + (AddrBits'(r_len) << SizeLog);
                        r_state   <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (w_beat_go) begin
                        if (r_count != {CountBits{1'b1}}) begin
                            r_count <= r_count + CountBits'(1);
                        end
                        if (w_last_beat) begin
                            r_beat  <= '0;
                            r_state <= r_final ? S_WRESP : S_PREP0;
                        end else begin
                            r_beat  <= r_beat + LenBits'(1);
                        end
                    end
                end
                S_WRESP: begin
                    if (w_resp_clear) begin
                        r_done       <= 1'b1;
                        r_done_words <= r_count;
                        r_done_error <= r_err;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Bursts whose write response is still pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outst <= 4'd0;
        end else begin
            case ({w_aw_hs, w_b_hs})
                2'b10:   r_outst <= r_outst + 4'd1;
                2'b01:   r_outst <= r_outst - 4'd1;
                default: r_outst <= r_outst;
            endcase
        end
    end

    // Registered W output buffer, refilled whenever the slave takes the current beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wvalid <= 1'b0;
            r_wdata  <= '0;
            r_wlast  <= 1'b0;
        end else if (w_beat_go) begin
            r_wvalid <= 1'b1;
            r_wdata  <= w_rd_entry[DataBits-1:0];
            r_wlast  <= w_last_beat;
        end else if (mst_wready) begin
            r_wvalid <= 1'b0;
            r_wlast  <= 1'b0;
        end
    end

`ifdef DMA_WR_KEEP_EN
    logic [BytesPerWord-1:0] r_wstrb;

    // Byte enables travel with their data beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstrb <= '0;
        end else if (w_beat_go) begin
            r_wstrb <= w_rd_entry[EntryBits-1:DataBits];
        end
    end

    assign mst_wstrb = r_wstrb;
`else
    assign mst_wstrb = {BytesPerWord{1'b1}};
`endif

    assign mst_awvalid = r_awvalid;
    assign mst_awaddr  = r_awaddr;
    assign mst_awlen   = r_awlen;
    assign mst_awsize  = 3'(SizeLog);
    assign mst_awburst = 2'b01;
    assign mst_awid    = 4'd0;
    assign mst_wvalid  = r_wvalid;
    assign mst_wdata   = r_wdata;
    assign mst_wlast   = r_wlast;
    assign mst_bready  = 1'b1;
    assign done        = r_done;
    assign done_words  = r_done_words;
    assign done_error  = r_done_error;

endmodule

// File: tb/tb_dma_writer_frame.sv
// Randomized bench for dma_writer_frame: expected bursts and data come from a frame-level model.
`timescale 1ns/1ps
module tb_dma_writer_frame;
    localparam int DW = 64;
    localparam int AW = 32;
    localparam int BS = 16;
    localparam int FD = 64;
    localparam int MO = 2;
    localparam int CW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            din_valid, din_ready, din_eof;
    logic [DW-1:0]   din_data;
`ifdef DMA_WR_KEEP_EN
    logic [DW/8-1:0] din_keep;
`endif
    logic            cfg_valid, cfg_ready;
    logic [AW-1:0]   cfg_addr;
    logic            mst_awvalid, mst_awready;
    logic [AW-1:0]   mst_awaddr;
    logic [7:0]      mst_awlen;
    logic [2:0]      mst_awsize;
    logic [1:0]      mst_awburst;
    logic [3:0]      mst_awid;
    logic            mst_wvalid, mst_wready, mst_wlast;
    logic [DW-1:0]   mst_wdata;
    logic [DW/8-1:0] mst_wstrb;
    logic            mst_bvalid, mst_bready;
    logic [1:0]      mst_bresp;
    logic            done;
    logic [CW-1:0]   done_words;
    logic [1:0]      done_error;

    always #5 clk = ~clk;

    dma_writer_frame #(
        .DataBits(DW), .AddrBits(AW), .BurstSize(BS), .FifoDepth(FD),
        .MaxOutstanding(MO), .CountBits(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data), .din_eof(din_eof),
`ifdef DMA_WR_KEEP_EN
        .din_keep(din_keep),
`endif
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
        .mst_awvalid(mst_awvalid), .mst_awready(mst_awready), .mst_awaddr(mst_awaddr),
        .mst_awlen(mst_awlen), .mst_awsize(mst_awsize), .mst_awburst(mst_awburst), .mst_awid(mst_awid),
        .mst_wvalid(mst_wvalid), .mst_wready(mst_wready), .mst_wdata(mst_wdata),
        .mst_wstrb(mst_wstrb), .mst_wlast(mst_wlast),
        .mst_bvalid(mst_bvalid), .mst_bready(mst_bready), .mst_bresp(mst_bresp),
        .done(done), .done_words(done_words), .done_error(done_error)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [DW:0]   src_q[$];
    logic [AW-1:0] cfg_q[$];
    logic [AW-1:0] exp_awaddr_q[$];
    logic [7:0]    exp_awlen_q[$];
    logic [DW-1:0] exp_wdata_q[$];
    int            exp_wlen_q[$];
    logic [1:0]    bresp_q[$];

    int         aw_cnt = 0, wl_cnt = 0, b_cnt = 0, w_beat = 0, done_cnt = 0;
    int         b_limit = 1 << 30;
    int         bresp_mode = 0;
    int         start_done = 0;
    int         exp_words = 0;
    logic [1:0] frame_err = 2'b00;
    logic [CW-1:0] last_done_words = '0;
    logic [1:0] last_done_err = 2'b00;
    bit         din_hs_s = 1'b0, cfg_hs_s = 1'b0, b_hs_s = 1'b0;

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Frame model: each burst is min(BurstSize, words to 4 KiB boundary, words left).
    task automatic start_frame(input logic [AW-1:0] addr, input int n);
        logic [AW-1:0] a;
        int rem, lim, blen;
        logic [DW-1:0] d;
        a = addr;
        rem = n;
        while (rem > 0) begin
            lim = (4096 - int'(a % 4096)) / (DW / 8);
            if (lim > BS) lim = BS;
            blen = (rem < lim) ? rem : lim;
            exp_awaddr_q.push_back(a);
            exp_awlen_q.push_back(8'(blen - 1));
            exp_wlen_q.push_back(blen);
            a = a + AW'(blen * (DW / 8));
            rem = rem - blen;
        end
        for (int i = 0; i < n; i++) begin
            d = {$urandom, $urandom};
            exp_wdata_q.push_back(d);
            src_q.push_back({(i == n - 1), d});
        end
        frame_err = 2'b00;
        exp_words = n;
        start_done = done_cnt;
        cfg_q.push_back(addr);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (done_cnt == start_done && k < budget) begin
            @(negedge clk); #2;
            k++;
        end
        chk_val({tag, "_done_seen"}, 64'(done_cnt != start_done), 64'd1);
        if (done_cnt != start_done) begin
            chk_val({tag, "_done_words"}, 64'(last_done_words), 64'(exp_words));
            chk_val({tag, "_done_error"}, 64'(last_done_err), 64'(frame_err));
        end
        chk_val({tag, "_aw_left"}, 64'(exp_awaddr_q.size()), 64'd0);
        chk_val({tag, "_w_left"}, 64'(exp_wdata_q.size()), 64'd0);
        repeat (4) @(negedge clk);
        #2;
        chk_val({tag, "_single_done"}, 64'(done_cnt - start_done), 64'd1);
    endtask

    task automatic flush_bench();
        src_q.delete(); cfg_q.delete(); exp_awaddr_q.delete(); exp_awlen_q.delete();
        exp_wdata_q.delete(); exp_wlen_q.delete(); bresp_q.delete();
        aw_cnt = 0; wl_cnt = 0; b_cnt = 0; w_beat = 0;
        b_limit = 1 << 30;
    endtask

    // Monitor: sample handshakes on the falling edge and score them against the model.
    always @(negedge clk) begin
        din_hs_s = din_valid && din_ready;
        cfg_hs_s = cfg_valid && cfg_ready;
        b_hs_s   = mst_bvalid && mst_bready;
        if (rst_n) begin
            if (mst_awvalid && mst_awready) begin
                aw_cnt++;
                if (exp_awaddr_q.size() == 0) begin
                    chk_val("aw_unexpected", 64'd1, 64'd0);
                end else begin
                    chk_val("awaddr", 64'(mst_awaddr), 64'(exp_awaddr_q.pop_front()));
                    chk_val("awlen", 64'(mst_awlen), 64'(exp_awlen_q.pop_front()));
                end
                chk_val("awsize_burst_id", 64'({mst_awsize, mst_awburst, mst_awid}), 64'({3'd3, 2'b01, 4'd0}));
                chk_val("no_4k_cross", 64'(int'(mst_awaddr % 4096) + (int'(mst_awlen) + 1) * 8 <= 4096), 64'd1);
                chk_val("outstanding_limit", 64'((aw_cnt - b_cnt) <= MO), 64'd1);
            end
            if (mst_wvalid && mst_wready) begin
                if (exp_wdata_q.size() == 0) begin
                    chk_val("w_unexpected", 64'd1, 64'd0);
                end else begin
                    chk_val("wdata", 64'(mst_wdata), 64'(exp_wdata_q.pop_front()));
                    w_beat++;
                    chk_val("wlast", 64'(mst_wlast), 64'(w_beat == exp_wlen_q[0]));
                    if (w_beat == exp_wlen_q[0]) begin
                        void'(exp_wlen_q.pop_front());
                        w_beat = 0;
                        wl_cnt++;
                    end
                end
                chk_val("wstrb", 64'(mst_wstrb), 64'(8'hFF));
            end
            if (b_hs_s) begin
                b_cnt++;
                if (mst_bresp > frame_err) frame_err = mst_bresp;
            end
            if (done) begin
                done_cnt++;
                last_done_words = done_words;
                last_done_err = done_error;
            end
        end
    end

    // Stimulus drivers: update all DUT inputs 1 ns after the rising edge.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                din_valid = 1'b0; cfg_valid = 1'b0; mst_bvalid = 1'b0;
            end else begin
                if (din_hs_s) begin
                    void'(src_q.pop_front());
                    din_valid = 1'b0;
                end
                if (!din_valid) begin
                    din_valid = (src_q.size() > 0) && ($urandom_range(0, 3) != 0);
                    if (din_valid) {din_eof, din_data} = src_q[0];
                end
                if (cfg_hs_s) begin
                    void'(cfg_q.pop_front());
                    cfg_valid = 1'b0;
                end
                if (!cfg_valid && cfg_q.size() > 0) begin
                    cfg_valid = 1'b1;
                    cfg_addr = cfg_q[0];
                end
                mst_awready = 1'($urandom_range(0, 1));
                mst_wready = ($urandom_range(0, 3) != 0);
                if (b_hs_s) begin
                    mst_bvalid = 1'b0;
                    if (bresp_q.size() > 0) void'(bresp_q.pop_front());
                end
                if (!mst_bvalid && b_cnt < aw_cnt && b_cnt < wl_cnt && b_cnt < b_limit
                    && $urandom_range(0, 2) != 0) begin
                    mst_bvalid = 1'b1;
                    if (bresp_q.size() > 0) mst_bresp = bresp_q[0];
                    else if (bresp_mode != 0) mst_bresp = 2'($urandom_range(0, 3));
                    else mst_bresp = 2'b00;
                end
            end
        end
    end

    initial begin
        int aw0, k;
        din_valid = 1'b0; din_data = '0; din_eof = 1'b0;
`ifdef DMA_WR_KEEP_EN
        din_keep = '1;
`endif
        cfg_valid = 1'b0; cfg_addr = '0;
        mst_awready = 1'b0; mst_wready = 1'b0; mst_bvalid = 1'b0; mst_bresp = 2'b00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_val("rst_awvalid", 64'(mst_awvalid), 64'd0);
        chk_val("rst_wvalid", 64'(mst_wvalid), 64'd0);
        chk_val("rst_done", 64'({done, done_words, done_error}), 64'd0);
        chk_val("rst_ready", 64'({cfg_ready, din_ready, mst_bready}), 64'(3'b111));
        @(posedge clk); #3;
        rst_n = 1'b1;

        start_frame(32'h0000_1000, 40);
        wait_done("t1", 3000);
        start_frame(32'h0000_0FC0, 20);
        wait_done("t2", 3000);

        b_limit = b_cnt;
        aw0 = aw_cnt;
        start_frame(32'h0000_3000, 64);
        repeat (300) @(negedge clk);
        #2;
        chk_val("t3_two_aw", 64'(aw_cnt - aw0), 64'd2);
        chk_val("t3_no_done_a", 64'(done_cnt), 64'(start_done));
        b_limit = b_cnt + 1;
        repeat (150) @(negedge clk);
        #2;
        chk_val("t3_third_aw", 64'(aw_cnt - aw0), 64'd3);
        chk_val("t3_no_done_b", 64'(done_cnt), 64'(start_done));
        b_limit = 1 << 30;
        wait_done("t3", 3000);

        bresp_q.push_back(2'b00); bresp_q.push_back(2'b10); bresp_q.push_back(2'b00);
        start_frame(32'h0000_5000, 48);
        wait_done("t4", 3000);
        chk_val("t4_slverr", 64'(last_done_err), 64'(2'b10));
        start_frame(32'h0000_5400, 24);
        wait_done("t4_next", 3000);
        chk_val("t4_err_cleared", 64'(last_done_err), 64'd0);

        start_frame(32'h0000_2000, 1);
        wait_done("t5", 1000);

        start_frame(32'h0000_1000, 40);
        k = 0;
        while (!mst_wvalid && k < 500) begin
            @(negedge clk); k++;
        end
        chk_val("t6_burst_started", 64'(mst_wvalid), 64'd1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk_val("t6_async_clear", 64'({mst_awvalid, mst_wvalid, done}), 64'd0);
        flush_bench();
        repeat (2) @(negedge clk);
        chk_val("t6_idle_after_rst", 64'(cfg_ready), 64'd1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        start_frame(32'h0000_6000, 40);
        wait_done("t6", 3000);

        bresp_mode = 1;
        for (int f = 0; f < 6; f++) begin
            start_frame(($urandom & 32'h000F_FFF8), int'($urandom_range(1, 100)));
            wait_done("rand", 5000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/dma_writer_frame.md
Name: dma_writer_frame

Overview:
Next-generation stream-to-AXI frame DMA writer. Each frame takes its start address from a config stream. Frame data is written until the word flagged EOF, using AXI4 incrementing bursts of up to 256 beats. Several bursts can be in flight at once, and completion is reported only after every write response for the frame has returned, together with the frame word count and an error status.

Parameters:
DataBits, 64, data width in bits; power of two, 8..1024
AddrBits, 32, address width in bits
BurstSize, 16, maximum beats per burst; 1..256
FifoDepth, 64, data fifo depth in words; must be >= BurstSize
MaxOutstanding, 4, maximum bursts issued whose bresp has not yet returned; 1..15
CountBits, 32, width of the frame word counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
din_valid/din_ready  in/out  1/1  input data stream handshake
din_data  in  DataBits  frame data word
din_eof  in  1  marks the last word of a frame
din_keep  in  DataBits/8  byte enables of the word (only when DMA_WR_KEEP_EN is defined)
cfg_valid/cfg_ready  in/out  1/1  config stream handshake
cfg_addr  in  AddrBits  frame start byte address; must be word aligned
mst_awvalid/mst_awready  out/in  1/1  AXI write address handshake
mst_awaddr  out  AddrBits  burst start address
mst_awlen  out  8  beats minus one
mst_awsize  out  3  clog2(DataBits/8)
mst_awburst  out  2  tied to 2'b01
mst_awid  out  4  tied to 0
mst_wvalid/mst_wready  out/in  1/1  AXI write data handshake
mst_wdata  out  DataBits  write data
mst_wstrb  out  DataBits/8  byte strobes
mst_wlast  out  1  last beat of burst
mst_bvalid/mst_bready  in/out  1/1  AXI write response handshake
mst_bresp  in  2  write response code
done  out  1  one-cycle pulse when a frame is complete
done_words  out  CountBits  words in the completed frame; valid while done=1
done_error  out  2  worst bresp of the frame (max code); valid while done=1

Behaviour:
- Reset (asynchronous, rst_n=0): state=Idle. mst_awvalid=0, mst_wvalid=0, done=0, done_words=0, done_error=0. Fifo, outstanding counter and EOF flag are cleared.
- Reset mid-frame abandons the frame. No done pulse is issued for it.
- cfg_ready=1 only in Idle. A cfg handshake latches the address, clears the word count and error status, and moves to Prep.
- Prep (2 cycles): until_4k=(4096-addr[11:0])/BytesPerWord; burst_len=min(BurstSize, until_4k). Bursts never cross a 4 KiB boundary.
- WaitFifo:
  - EOF word held in the fifo and used<=burst_len: burst_len=used, mark final burst, go to Issue.
  - Otherwise, used>=burst_len: go to Issue.
- Issue:
  - Stalls while outstanding==MaxOutstanding.
  - Otherwise asserts awvalid with awaddr=addr and awlen=burst_len-1, then advances addr by burst_len*BytesPerWord. The address is registered.
  - awvalid holds until awready. The data phase does not wait for the aw handshake.
- DoBurst:
  - Moves burst_len beats from fifo to W through a registered output buffer; wlast is set on the final beat.
  - Each beat increments the word count.
  - Goes to Prep, or to WaitResp if this was the final burst.
- WaitResp: waits until the W buffer is empty and outstanding==0, then pulses done for 1 cycle and returns to Idle.
- Outstanding counter: +1 on aw handshake, -1 on b handshake. A simultaneous aw and b handshake leaves it unchanged.
- mst_bready is always 1. done_error=max(done_error, bresp) on every b handshake.
- EOF backpressure: once an EOF word is accepted, din_ready stays 0 until the final burst decision is made. The fifo therefore never holds two frames.
- din_ready is also 0 when the fifo is full.
- Word count saturates at 2^CountBits-1.

Optional Feature:
DMA_WR_KEEP_EN:
- Defined: din_keep port exists and is stored in the fifo alongside the data; mst_wstrb carries it beat by beat.
- Undefined: din_keep port is absent and mst_wstrb is all ones.

Test Plan:
1. DataBits=64, BurstSize=16; 40-word frame at 0x1000 -> aw (0x1000, len15), (0x1080, len15), (0x1100, len7); done after the 3rd bresp; done_words=40, done_error=0.
2. Frame of 20 words at 0x0FC0 -> aw (0x0FC0, len7) then (0x1000, len11); no burst crosses 0x1000.
3. MaxOutstanding=2, bvalid held low, 64-word frame -> exactly 2 aw handshakes occur. Releasing bvalid for one response allows the 3rd aw; done only after all 4 bresp.
4. bresp OKAY, SLVERR, OKAY on a 3-burst frame -> done_error=2'b10. The next frame starts with done_error cleared.
5. Single-word frame at 0x2000 -> awlen=0, wlast on beat 1, done_words=1.
6. rst_n pulsed low during DoBurst -> awvalid, wvalid and done go to 0 immediately (asynchronously). The next cfg starts a clean frame with correct addresses.
